// File: rtl/period_meter_pkg.sv
// Shared state encoding and default sizing for the period meter.
package period_meter_pkg;

  localparam int STATE_W     = 2;
  localparam int DEF_CNT_W   = 24;
  localparam int DEF_TIMEOUT = 10000000;
  localparam int DEF_TOL     = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TOUT    = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus previous-value register; yields the synchronised
// level and one-cycle rise/fall pulses. Reusable for push-buttons.
module sync_edge_detect (
  input  logic CLK_5_MHZ,
  input  logic reset,
  input  logic sig_in,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge CLK_5_MHZ or posedge reset) begin
    if (reset) begin
      meta  <= 1'b0;
      sig_s <= 1'b0;
      prev  <= 1'b0;
    end else begin
      meta  <= sig_in;
      sig_s <= meta;
      prev  <= sig_s;
    end
  end

  assign rise = sig_s & ~prev;
  assign fall = ~sig_s & prev;

endmodule

// File: rtl/period_meter.sv
// Measures rise-to-rise period of a slow async input in CLK_5_MHZ cycles, with
// timeout and lock flags. Define PERIOD_METER_HIGH_TIME_EN to add high_time.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TOL     = DEF_TOL
) (
  input  logic             CLK_5_MHZ,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
`ifdef PERIOD_METER_HIGH_TIME_EN
  output logic             locked,
  output logic [CNT_W-1:0] high_time
`else
  output logic             locked
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);

  // Unsigned distance between two periods, one bit wider so it cannot overflow.
  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    if (a >= b) return {1'b0, a} - {1'b0, b};
    else        return {1'b0, b} - {1'b0, a};
  endfunction

  logic       sig_s;
  logic       rise;
  logic       fall;
  state_t     state;
  logic [CNT_W-1:0] count;
  logic       have_prev;

  sync_edge_detect u_sync (
    .CLK_5_MHZ (CLK_5_MHZ),
    .reset     (reset),
    .sig_in    (sig_in),
    .sig_s     (sig_s),
    .rise      (rise),
    .fall      (fall)
  );

  always_ff @(posedge CLK_5_MHZ or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      count        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      locked       <= 1'b0;
      have_prev    <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          count <= '0;
          if (rise) begin
            state <= ST_MEASURE;
            count <= CNT_ONE;
          end
        end
        ST_MEASURE: begin
          // A rise landing exactly on count == TIMEOUT still reports a period.
          if (rise) begin
            period       <= count;
            period_valid <= 1'b1;
            count        <= CNT_ONE;
            locked       <= have_prev && (abs_diff(count, period) <= TOL_C);
            have_prev    <= 1'b1;
          end else if (count == TIMEOUT_C) begin
            state     <= ST_TOUT;
            timeout   <= 1'b1;
            locked    <= 1'b0;
            have_prev <= 1'b0;
          end else begin
            count <= count + CNT_ONE;
          end
        end
        ST_TOUT: begin
          if (rise) begin
            state   <= ST_MEASURE;
            timeout <= 1'b0;
            count   <= CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [CNT_W-1:0] high_cnt;

  // The rise cycle itself is already high, so the count restarts at one.
  always_ff @(posedge CLK_5_MHZ or posedge reset) begin
    if (reset) begin
      high_cnt  <= '0;
      high_time <= '0;
    end else begin
      if (rise)
        high_cnt <= CNT_ONE;
      else if (sig_s && (high_cnt != '1))
        high_cnt <= high_cnt + CNT_ONE;
      if (fall && (state == ST_MEASURE))
        high_time <= high_cnt;
    end
  end
`else
  logic unused_edge;
  assign unused_edge = &{1'b0, sig_s, fall};
`endif

endmodule

// File: tb/tb_period_meter.sv
// Randomised scoreboard bench for period_meter against a rise-time based model.
module tb_period_meter;

  localparam int CNT_W   = 24;
  localparam int TIMEOUT = 1000;
  localparam int TOL     = 4;
  localparam int LAT     = 3;

  logic CLK_5_MHZ = 1'b0;
  logic reset     = 1'b1;
  logic sig_in    = 1'b0;
  logic [CNT_W-1:0] period;
  logic period_valid, timeout, locked;
`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [CNT_W-1:0] high_time;
`endif

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOL(TOL)) dut (
    .CLK_5_MHZ    (CLK_5_MHZ),
    .reset        (reset),
    .sig_in       (sig_in),
    .period       (period),
    .period_valid (period_valid),
    .timeout      (timeout),
`ifdef PERIOD_METER_HIGH_TIME_EN
    .locked       (locked),
    .high_time    (high_time)
`else
    .locked       (locked)
`endif
  );

  always #100 CLK_5_MHZ = ~CLK_5_MHZ;

  longint cyc = 0;
  always @(posedge CLK_5_MHZ) cyc <= cyc + 1;

  typedef struct {
    longint cyc;
    longint val;
    bit     lk;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   hi_q[$];
  longint rise_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: sig_in rising/falling steps as driven.
  longint m_last_k = -1;
  longint m_rise_k = 0;
  longint m_period = 0;
  bit     m_have_prev = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_rise(input longint k);
    longint gap, d;
    gap = k - m_last_k;
    if (m_last_k >= 0 && gap <= TIMEOUT) begin
      d = gap - m_period;
      if (d < 0) d = -d;
      exp_q.push_back('{k + LAT, gap, m_have_prev && (d <= TOL)});
      m_period    = gap;
      m_have_prev = 1;
    end else begin
      m_have_prev = 0;
    end
    m_last_k = k;
    m_rise_k = k;
    rise_q.push_back(k + LAT);
  endtask

  task automatic model_fall(input longint k);
    hi_q.push_back('{k + LAT, k - m_rise_k, 1'b0});
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK_5_MHZ);
      #1;
      if (v && !sig_in) model_rise(cyc);
      else if (!v && sig_in) model_fall(cyc);
      sig_in = v;
    end
  endtask

  task automatic wave(input int h, input int l, input int reps);
    for (int r = 0; r < reps; r++) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_valid"}, period_valid, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_locked"}, locked, 0);
`ifdef PERIOD_METER_HIGH_TIME_EN
    check({tag, "_high_time"}, high_time, 0);
`endif
  endtask

  task automatic do_reset();
    @(posedge CLK_5_MHZ);
    #1;
    reset = 1'b1;
    exp_q.delete();
    hi_q.delete();
    rise_q.delete();
    m_last_k = -1;
    m_period = 0;
    m_have_prev = 0;
    #1;
    check_zero_outputs("async_reset");
    repeat (2) @(posedge CLK_5_MHZ);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: per-cycle expectations derived from registered rise times.
  initial begin
    longint mon_last_reg = 0;
    bit     mon_have = 0;
    longint mon_period = 0;
    bit     mon_locked = 0;
    longint mon_high = 0;
    bit     prev_valid = 0;
    bit     to_exp;
    exp_t   e;
    forever begin
      @(negedge CLK_5_MHZ);
      if (reset) begin
        mon_have = 0; mon_period = 0; mon_locked = 0; mon_high = 0; prev_valid = 0;
      end else begin
        while (rise_q.size() > 0 && rise_q[0] <= cyc) begin
          mon_last_reg = rise_q.pop_front();
          mon_have = 1;
        end
        to_exp = mon_have && ((cyc - mon_last_reg) >= TIMEOUT);
        if (to_exp) mon_locked = 0;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          check("strobe_present", 0, 1);
        end
        if (period_valid) begin
          check("valid_not_back_to_back", prev_valid, 0);
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("strobe_cycle", cyc, e.cyc);
            check("strobe_period", period, e.val);
            check("strobe_locked", locked, e.lk);
            mon_period = e.val;
            mon_locked = e.lk;
          end
        end
        check("period_held", period, mon_period);
        check("timeout", timeout, to_exp);
        check("locked", locked, mon_locked);
`ifdef PERIOD_METER_HIGH_TIME_EN
        while (hi_q.size() > 0 && hi_q[0].cyc <= cyc) begin
          e = hi_q.pop_front();
          mon_high = e.val;
        end
        check("high_time", high_time, mon_high);
`endif
        prev_valid = period_valid;
      end
    end
  end

  initial begin
    int p, h;
    #1;
    check_zero_outputs("reset_state");
    repeat (3) @(posedge CLK_5_MHZ);
    #1;
    reset = 1'b0;
    drive(1'b0, 5);

    // Lock-in at 100, step to 120, back to 100, then a small step to 103.
    wave(50, 50, 4);
    wave(60, 60, 3);
    wave(50, 50, 2);
    wave(50, 53, 2);

    // Loss of signal, then recovery.
    drive(1'b1, 50);
    drive(1'b0, 1200);
    wave(50, 50, 3);

    // Period exactly TIMEOUT, then one cycle beyond it.
    wave(50, 950, 3);
    wave(50, 951, 1);
    wave(50, 50, 3);

    // Randomised periods, occasionally straddling TIMEOUT.
    for (int i = 0; i < 25; i++) begin
      if ((i % 8) == 7) begin
        p = $urandom_range(995, 1005);
        h = $urandom_range(1, 100);
      end else begin
        p = $urandom_range(2, 220);
        h = $urandom_range(1, p - 1);
      end
      wave(h, p - h, 1);
    end

    // Reset part-way through a measurement; next rise counts as first.
    wave(50, 50, 2);
    drive(1'b1, 10);
    drive(1'b0, 50);
    do_reset();
    wave(50, 50, 3);

    // Asymmetric duty cycle.
    wave(30, 70, 4);

    drive(1'b0, 10);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
